// File: rtl/rr_arb6.sv
// Six-requester round-robin arbiter with grant hold, owner release and hold-limit timeout.
// Each lane decides whether it is the first active request at or after the rotating pointer.

module rr_arb6_lane #(
    parameter int NUM_LANES = 6,
    parameter int IDX       = 0
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [2:0]           ptr,
    output logic                 win
);
    int  my_d;
    int  dj;
    logic blocked;

    // A lane wins when no active request sits closer to the pointer in rotation order.
    always_comb begin
        my_d    = (IDX + NUM_LANES - int'(ptr)) % NUM_LANES;
        dj      = 0;
        blocked = 1'b0;
        for (int j = 0; j < NUM_LANES; j++) begin
            dj = (j + NUM_LANES - int'(ptr)) % NUM_LANES;
            if (req[j] && (dj < my_d)) blocked = 1'b1;
        end
        win = req[IDX] && !blocked;
    end
endmodule

module rr_arb6 #(
    parameter int MAX_HOLD = 16,
    parameter int TW       = 5
) (
    input  logic       CK,
    input  logic       RN,
    input  logic [5:0] REQ,
    input  logic       DONE,
    output logic [5:0] GNT,
    output logic [2:0] GID,
    output logic       BUSY,
    output logic       ANYREQ,
    output logic       TOUT
);
    localparam int          NUM_LANES = 6;
    localparam bit          HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_EN ? MAX_HOLD - 1 : 0);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                state_q, state_d;
    logic [2:0]            ptr_q, ptr_d;
    logic [2:0]            gid_d, sel;
    logic [5:0]            gnt_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic                  tout_d;
    logic                  rel_own, hit;
    logic [NUM_LANES-1:0]  win;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            rr_arb6_lane #(.NUM_LANES(NUM_LANES), .IDX(gi)) u_lane (
                .req (REQ),
                .ptr (ptr_q),
                .win (win[gi])
            );
        end
    endgenerate

    assign ANYREQ = |REQ;
    assign BUSY   = (state_q == GRANT);

    always_comb begin
        sel = 3'd0;
        for (int i = 0; i < NUM_LANES; i++)
            if (win[i]) sel = 3'(i);
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = GNT;
        gid_d   = GID;
        ptr_d   = ptr_q;
        tmr_d   = tmr_q;
        tout_d  = 1'b0;
        rel_own = DONE || !REQ[GID];
        hit     = HOLD_EN && (tmr_q == HOLD_LAST);
        case (state_q)
            IDLE: begin
                if (ANYREQ) begin
                    state_d = GRANT;
                    gnt_d   = win;
                    gid_d   = sel;
                    tmr_d   = '0;
                end
            end
            GRANT: begin
                if (rel_own || hit) begin
                    // Owner release takes precedence over timeout for TOUT reporting.
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = (GID == 3'd5) ? 3'd0 : GID + 3'd1;
                    tout_d  = hit && !rel_own;
                end else if (tmr_q != '1) begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (!RN) begin
            state_q <= IDLE;
            GNT     <= '0;
            GID     <= '0;
            ptr_q   <= '0;
            tmr_q   <= '0;
            TOUT    <= 1'b0;
        end else begin
            state_q <= state_d;
            GNT     <= gnt_d;
            GID     <= gid_d;
            ptr_q   <= ptr_d;
            tmr_q   <= tmr_d;
            TOUT    <= tout_d;
        end
    end
endmodule

// File: tb/tb_rr_arb6.sv
// Bench for rr_arb6: directed scenarios plus randomized traffic against a
// cycle-level reference model built from the arbitration rules.

module tb_rr_arb6;
    localparam int MAX_HOLD = 16;

    logic       CK = 1'b0;
    logic       RN, DONE;
    logic [5:0] REQ, GNT;
    logic [2:0] GID;
    logic       BUSY, ANYREQ, TOUT;

    int checks = 0;
    int errors = 0;

    bit m_busy, m_tout;
    int m_gid, m_ptr, m_held;

    rr_arb6 #(.MAX_HOLD(MAX_HOLD), .TW(5)) dut (
        .CK(CK), .RN(RN), .REQ(REQ), .DONE(DONE),
        .GNT(GNT), .GID(GID), .BUSY(BUSY), .ANYREQ(ANYREQ), .TOUT(TOUT)
    );

    always #5 CK = ~CK;

    function automatic int pick(logic [5:0] r, int p);
        for (int k = 0; k < 6; k++) begin
            int i;
            i = (p + k) % 6;
            if (r[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [5:0] m_gnt();
        logic [5:0] v;
        v = '0;
        if (m_busy) v[m_gid] = 1'b1;
        return v;
    endfunction

    task automatic model_edge(input logic [5:0] r, input logic d, input logic rn);
        bit a, b, c;
        if (!rn) begin
            m_busy = 0; m_gid = 0; m_ptr = 0; m_held = 0; m_tout = 0;
        end else if (!m_busy) begin
            m_tout = 0;
            if (r != 0) begin
                m_gid = pick(r, m_ptr); m_busy = 1; m_held = 1;
            end
        end else begin
            a = d;
            b = !r[m_gid];
            c = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
            if (a || b || c) begin
                m_busy = 0;
                m_ptr  = (m_gid + 1) % 6;
                m_tout = c && !a && !b;
            end else begin
                m_held++;
                m_tout = 0;
            end
        end
    endtask

    task automatic step(input logic [5:0] r, input logic d, input logic rn);
        REQ = r; DONE = d; RN = rn;
        @(posedge CK);
        model_edge(r, d, rn);
        #1;
    endtask

    task automatic test_reset();
        step(6'h3F, 1'b0, 1'b0);
        step(6'h3F, 1'b0, 1'b0);
        checks++; if (GNT !== 6'h00) begin errors++; $display("FAIL reset_gnt got %h want 00", GNT); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", BUSY); end
        checks++; if (GID !== 3'd0) begin errors++; $display("FAIL reset_gid got %0d want 0", GID); end
        checks++; if (TOUT !== 1'b0) begin errors++; $display("FAIL reset_tout got %b want 0", TOUT); end
        checks++; if (ANYREQ !== 1'b1) begin errors++; $display("FAIL reset_anyreq got %b want 1", ANYREQ); end
    endtask

    task automatic test_rotation();
        int e;
        for (int n = 0; n < 7; n++) begin
            e = n % 6;
            step(6'h3F, 1'b0, 1'b1);
            checks++;
            if (BUSY !== 1'b1 || GID !== 3'(e) || GNT !== 6'(1 << e)) begin
                errors++; $display("FAIL rotation_grant n=%0d got busy=%b gid=%0d gnt=%h want gid=%0d", n, BUSY, GID, GNT, e);
            end
            step(6'h3F, 1'b1, 1'b1);
            checks++;
            if (BUSY !== 1'b0 || GNT !== 6'h00) begin
                errors++; $display("FAIL rotation_dead n=%0d got busy=%b gnt=%h want idle", n, BUSY, GNT);
            end
        end
    endtask

    task automatic test_wrap_priority();
        step(6'h20, 1'b0, 1'b1);
        checks++; if (GID !== 3'd5 || BUSY !== 1'b1) begin errors++; $display("FAIL wrap_g5 got gid=%0d busy=%b want 5/1", GID, BUSY); end
        step(6'h20, 1'b1, 1'b1);
        step(6'h03, 1'b0, 1'b1);
        checks++; if (GID !== 3'd0 || GNT !== 6'h01) begin errors++; $display("FAIL wrap_g0 got gid=%0d gnt=%h want 0/01", GID, GNT); end
        step(6'h03, 1'b1, 1'b1);
        step(6'h03, 1'b0, 1'b1);
        checks++; if (GID !== 3'd1 || GNT !== 6'h02) begin errors++; $display("FAIL wrap_g1 got gid=%0d gnt=%h want 1/02", GID, GNT); end
        step(6'h03, 1'b1, 1'b1);
    endtask

    task automatic test_timeout();
        int cnt;
        bit tout_seen;
        cnt = 0; tout_seen = 0;
        step(6'h04, 1'b0, 1'b1);
        while (GNT == 6'h04 && cnt < 40) begin
            cnt++;
            checks++; if (TOUT !== 1'b0) begin errors++; $display("FAIL timeout_early_tout at %0d got %b want 0", cnt, TOUT); end
            step(6'h04, 1'b0, 1'b1);
        end
        checks++; if (cnt != MAX_HOLD) begin errors++; $display("FAIL timeout_len got %0d want %0d", cnt, MAX_HOLD); end
        checks++; if (TOUT !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("FAIL timeout_pulse got tout=%b busy=%b want 1/0", TOUT, BUSY); end
        step(6'h04, 1'b0, 1'b1);
        checks++; if (GNT !== 6'h04 || TOUT !== 1'b0) begin errors++; $display("FAIL timeout_regrant got gnt=%h tout=%b want 04/0", GNT, TOUT); end
        step(6'h04, 1'b1, 1'b1);
    endtask

    task automatic test_simultaneous();
        step(6'h04, 1'b0, 1'b1);
        for (int k = 0; k < MAX_HOLD - 1; k++) step(6'h04, 1'b0, 1'b1);
        checks++; if (GNT !== 6'h04) begin errors++; $display("FAIL sim_hold got gnt=%h want 04", GNT); end
        step(6'h04, 1'b1, 1'b1);
        checks++; if (TOUT !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL sim_done_tout got tout=%b busy=%b want 0/0", TOUT, BUSY); end
        step(6'h04, 1'b0, 1'b1);
        for (int k = 0; k < MAX_HOLD - 1; k++) step(6'h04, 1'b0, 1'b1);
        step(6'h00, 1'b0, 1'b1);
        checks++; if (TOUT !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL sim_drop_tout got tout=%b busy=%b want 0/0", TOUT, BUSY); end
        step(6'h04, 1'b0, 1'b1);
        step(6'h00, 1'b0, 1'b1);
        checks++; if (BUSY !== 1'b0 || TOUT !== 1'b0) begin errors++; $display("FAIL drop_release got busy=%b tout=%b want 0/0", BUSY, TOUT); end
    endtask

    task automatic test_reset_mid_grant();
        step(6'h08, 1'b0, 1'b1);
        checks++; if (GNT !== 6'h08) begin errors++; $display("FAIL midrst_pre got gnt=%h want 08", GNT); end
        step(6'h09, 1'b0, 1'b0);
        checks++; if (GNT !== 6'h00 || GID !== 3'd0 || TOUT !== 1'b0) begin errors++; $display("FAIL midrst_clear got gnt=%h gid=%0d tout=%b", GNT, GID, TOUT); end
        step(6'h09, 1'b0, 1'b1);
        checks++; if (GID !== 3'd0 || GNT !== 6'h01) begin errors++; $display("FAIL midrst_ptr got gid=%0d gnt=%h want 0/01", GID, GNT); end
        step(6'h09, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        logic [5:0] r;
        logic d, rn;
        r = 6'($urandom);
        step(6'h00, 1'b0, 1'b0);
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 9) == 0) r = 6'($urandom);
            if ($urandom_range(0, 15) == 0) r[$urandom_range(0, 5)] = 1'b0;
            d  = ($urandom_range(0, 11) == 0);
            rn = ($urandom_range(0, 99) != 0);
            step(r, d, rn);
            checks++;
            if (GNT !== m_gnt() || GID !== 3'(m_gid) || BUSY !== m_busy || TOUT !== m_tout || ANYREQ !== (|r)) begin
                errors++;
                $display("FAIL random n=%0d got gnt=%h gid=%0d busy=%b tout=%b any=%b want gnt=%h gid=%0d busy=%b tout=%b any=%b",
                         n, GNT, GID, BUSY, TOUT, ANYREQ, m_gnt(), m_gid, m_busy, m_tout, |r);
            end
        end
    endtask

    initial begin
        REQ = '0; DONE = 1'b0; RN = 1'b0;
        m_busy = 0; m_gid = 0; m_ptr = 0; m_held = 0; m_tout = 0;
        test_reset();
        test_rotation();
        test_wrap_priority();
        test_timeout();
        test_simultaneous();
        test_reset_mid_grant();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
